// File: rtl/axistream_snooper.sv
// Passive AXI-Stream tap that copies whole packets into a packet buffer write port.
// Packets that cannot be taken are counted as drops; packets that overflow the buffer are counted as truncated.
module axistream_snooper #(
    parameter int SNOOP_FWD_ADDR_WIDTH = 9,
    parameter int DATA_WIDTH           = 64,
    parameter int CNT_WIDTH            = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [DATA_WIDTH-1:0]           tap_tdata,
    input  logic                            tap_tvalid,
    input  logic                            tap_tready,
    input  logic                            tap_tlast,
    input  logic                            ready_for_snooper,
    output logic [SNOOP_FWD_ADDR_WIDTH-1:0] snooper_wr_addr,
    output logic [DATA_WIDTH-1:0]           snooper_wr_data,
    output logic                            snooper_wr_en,
    output logic                            snooper_done,
    output logic [CNT_WIDTH-1:0]            drop_count,
    output logic [CNT_WIDTH-1:0]            trunc_count
);

    localparam int AW = SNOOP_FWD_ADDR_WIDTH;

    typedef enum logic [1:0] {IDLE, CAPTURE, DROP, DONE} state_t;

    state_t                state, state_nxt;
    logic [AW-1:0]         wr_ptr, wr_ptr_nxt;
    logic                  full, full_nxt;
    logic                  trunc, trunc_nxt;
    logic [AW-1:0]         addr_nxt;
    logic [DATA_WIDTH-1:0] data_nxt;
    logic                  we_nxt, done_nxt;
    logic                  drop_inc, trunc_inc;
    logic                  beat;

    assign beat = tap_tvalid & tap_tready;

    always_comb begin
        state_nxt  = state;
        wr_ptr_nxt = wr_ptr;
        full_nxt   = full;
        trunc_nxt  = trunc;
        addr_nxt   = snooper_wr_addr;
        data_nxt   = snooper_wr_data;
        we_nxt     = 1'b0;
        done_nxt   = 1'b0;
        drop_inc   = 1'b0;
        trunc_inc  = 1'b0;
        case (state)
            IDLE: begin
                if (beat) begin
                    if (ready_for_snooper) begin
                        we_nxt     = 1'b1;
                        addr_nxt   = '0;
                        data_nxt   = tap_tdata;
                        wr_ptr_nxt = AW'(1);
                        full_nxt   = 1'b0;
                        trunc_nxt  = 1'b0;
                        state_nxt  = tap_tlast ? DONE : CAPTURE;
                    end else begin
                        drop_inc  = 1'b1;
                        state_nxt = tap_tlast ? IDLE : DROP;
                    end
                end
            end
            CAPTURE: begin
                if (beat) begin
                    // full latches once the top word is written; later beats only mark truncation
                    if (!full) begin
                        we_nxt     = 1'b1;
                        addr_nxt   = wr_ptr;
                        data_nxt   = tap_tdata;
                        wr_ptr_nxt = wr_ptr + AW'(1);
                        full_nxt   = &wr_ptr;
                    end else begin
                        trunc_nxt = 1'b1;
                    end
                    if (tap_tlast) state_nxt = DONE;
                end
            end
            DROP: begin
                if (beat && tap_tlast) state_nxt = IDLE;
            end
            DONE: begin
                done_nxt  = 1'b1;
                trunc_inc = trunc;
                state_nxt = IDLE;
                // a first beat landing here cannot be captured in time
                if (beat) begin
                    drop_inc  = 1'b1;
                    state_nxt = tap_tlast ? IDLE : DROP;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= IDLE;
            wr_ptr          <= '0;
            full            <= 1'b0;
            trunc           <= 1'b0;
            snooper_wr_addr <= '0;
            snooper_wr_data <= '0;
            snooper_wr_en   <= 1'b0;
            snooper_done    <= 1'b0;
            drop_count      <= '0;
            trunc_count     <= '0;
        end else begin
            state           <= state_nxt;
            wr_ptr          <= wr_ptr_nxt;
            full            <= full_nxt;
            trunc           <= trunc_nxt;
            snooper_wr_addr <= addr_nxt;
            snooper_wr_data <= data_nxt;
            snooper_wr_en   <= we_nxt;
            snooper_done    <= done_nxt;
            if (drop_inc && !(&drop_count))   drop_count  <= drop_count + 1'b1;
            if (trunc_inc && !(&trunc_count)) trunc_count <= trunc_count + 1'b1;
        end
    end

endmodule
